// File: rtl/img_pkg.sv
// Shared definitions for the frame-buffer writer and reader.
//   state_t       : writer control states (IDLE, WAIT_SOF, WRITE)
//   DEF_*         : default image geometry and pixel packing, kept in one
//                   place so writer and reader agree on the frame layout.
package img_pkg;

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        WAIT_SOF = 2'd1,
        WRITE    = 2'd2
    } state_t;

    localparam int DEF_RGB_WIDTH  = 24;
    localparam int DEF_DATA_WIDTH = 8;
    localparam int DEF_IMG_WIDTH  = 170;
    localparam int DEF_IMG_HEIGHT = 240;

endpackage

// File: rtl/img_addr_counter.sv
// Raster position counter: x/y plus a running linear index (y*IMG_WIDTH + x)
// kept without a multiplier.
// Ports:
//   clk, reset : clock, synchronous active-high reset (counters to 0)
//   clear      : restart the raster at position 0 this cycle
//   inc        : advance one pixel; combined with clear the counter lands on
//                position 1 (pixel 0 consumed in the same cycle)
//   index      : current linear position
//   last       : current position is the final pixel of the frame
module img_addr_counter
    import img_pkg::*;
#(
    parameter int IMG_WIDTH  = DEF_IMG_WIDTH,
    parameter int IMG_HEIGHT = DEF_IMG_HEIGHT,
    parameter int ADDR_WIDTH = $clog2(IMG_WIDTH * IMG_HEIGHT)
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  clear,
    input  logic                  inc,
    output logic [ADDR_WIDTH-1:0] index,
    output logic                  last
);

    localparam int X_WIDTH = $clog2(IMG_WIDTH);
    localparam int Y_WIDTH = $clog2(IMG_HEIGHT);
    localparam logic [X_WIDTH-1:0]    X_MAX   = X_WIDTH'(IMG_WIDTH - 1);
    localparam logic [Y_WIDTH-1:0]    Y_MAX   = Y_WIDTH'(IMG_HEIGHT - 1);
    localparam logic [ADDR_WIDTH-1:0] IDX_MAX = ADDR_WIDTH'(IMG_WIDTH * IMG_HEIGHT - 1);

    logic [X_WIDTH-1:0]    x, x_base, x_next;
    logic [Y_WIDTH-1:0]    y, y_base, y_next;
    logic [ADDR_WIDTH-1:0] idx_base, idx_next;

    always_comb begin
        x_base   = clear ? '0 : x;
        y_base   = clear ? '0 : y;
        idx_base = clear ? '0 : index;
        x_next   = x_base;
        y_next   = y_base;
        idx_next = idx_base;
        if (inc) begin
            if (x_base == X_MAX) begin
                x_next = '0;
                y_next = (y_base == Y_MAX) ? '0 : y_base + 1'b1;
            end else begin
                x_next = x_base + 1'b1;
            end
            // Wraps together with x/y so the index can never leave the frame.
            idx_next = (idx_base == IDX_MAX) ? '0 : idx_base + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            x     <= '0;
            y     <= '0;
            index <= '0;
        end else begin
            x     <= x_next;
            y     <= y_next;
            index <= idx_next;
        end
    end

    assign last = (x == X_MAX) && (y == Y_MAX);

endmodule

// File: rtl/img_writer.sv
// Frame-buffer writer: arms on start_write, waits for i_sof, then writes one
// IMG_WIDTH x IMG_HEIGHT frame of the i_de-qualified RGB stream into the
// frame buffer write port.
// Ports:
//   clk, reset          : clock, synchronous active-high reset
//   start_write         : arm request, honoured only when idle
//   i_sof, i_de         : start-of-frame marker, pixel valid
//   i_r, i_g, i_b       : pixel channels
//   addr, we, wdata     : registered buffer write port (1-cycle latency)
//   busy                : waiting for sof or writing
//   done                : pulse with the final write of a frame
//   frame_err           : pulse when sof restarts a partially written frame
module img_writer
    import img_pkg::*;
#(
    parameter int RGB_WIDTH  = DEF_RGB_WIDTH,
    parameter int DATA_WIDTH = DEF_DATA_WIDTH,
    parameter int IMG_WIDTH  = DEF_IMG_WIDTH,
    parameter int IMG_HEIGHT = DEF_IMG_HEIGHT,
    parameter int ADDR_WIDTH = $clog2(IMG_WIDTH * IMG_HEIGHT)
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  start_write,
    input  logic                  i_sof,
    input  logic                  i_de,
    input  logic [DATA_WIDTH-1:0] i_r,
    input  logic [DATA_WIDTH-1:0] i_g,
    input  logic [DATA_WIDTH-1:0] i_b,
    output logic [ADDR_WIDTH-1:0] addr,
    output logic                  we,
    output logic [RGB_WIDTH-1:0]  wdata,
    output logic                  busy,
    output logic                  done,
    output logic                  frame_err
);

    state_t                state, state_next;
    logic                  cnt_clear, cnt_inc, cnt_last;
    logic [ADDR_WIDTH-1:0] cnt_index, wr_addr;
    logic                  wr_en, done_set, err_set;

    img_addr_counter #(
        .IMG_WIDTH (IMG_WIDTH),
        .IMG_HEIGHT(IMG_HEIGHT),
        .ADDR_WIDTH(ADDR_WIDTH)
    ) u_counter (
        .clk  (clk),
        .reset(reset),
        .clear(cnt_clear),
        .inc  (cnt_inc),
        .index(cnt_index),
        .last (cnt_last)
    );

    always_comb begin
        state_next = state;
        cnt_clear  = 1'b0;
        cnt_inc    = 1'b0;
        wr_en      = 1'b0;
        done_set   = 1'b0;
        err_set    = 1'b0;
        case (state)
            IDLE: begin
                if (start_write) state_next = WAIT_SOF;
            end
            WAIT_SOF: begin
                if (i_sof) begin
                    state_next = WRITE;
                    cnt_clear  = 1'b1;
                    wr_en      = i_de;
                    cnt_inc    = i_de;
                end
            end
            WRITE: begin
                if (i_sof) begin
                    // Restart wins over a coincident last pixel; a repeated
                    // sof before any pixel was written is not an error.
                    cnt_clear = 1'b1;
                    err_set   = (cnt_index != '0);
                    wr_en     = i_de;
                    cnt_inc   = i_de;
                end else if (i_de) begin
                    wr_en   = 1'b1;
                    cnt_inc = 1'b1;
                    if (cnt_last) begin
                        // Counter wraps to 0 on its own with this increment.
                        done_set   = 1'b1;
                        state_next = IDLE;
                    end
                end
            end
            default: state_next = IDLE;
        endcase
    end

    assign wr_addr = cnt_clear ? '0 : cnt_index;

    // Output register stage
    always_ff @(posedge clk) begin
        if (reset) begin
            state     <= IDLE;
            we        <= 1'b0;
            addr      <= '0;
            wdata     <= '0;
            busy      <= 1'b0;
            done      <= 1'b0;
            frame_err <= 1'b0;
        end else begin
            state     <= state_next;
            we        <= wr_en;
            busy      <= (state_next != IDLE);
            done      <= done_set;
            frame_err <= err_set;
            if (wr_en) begin
                addr  <= wr_addr;
                wdata <= {i_r, i_g, i_b};
            end
        end
    end

endmodule

// File: doc/img_writer.md
Name: img_writer

Overview:
- Frame-buffer writer: receives a raster RGB pixel stream (data-enable qualified, with start-of-frame marker) and writes exactly one IMG_WIDTH x IMG_HEIGHT frame into the dual-port frame buffer.
- Counterpart of the frame-buffer reader: the reader drains the buffer toward the display/processing path, and this block fills it from the camera/processing path.
- Armed per frame by a start command. Reports busy, frame-done and frame-error status.

Parameters:
- RGB_WIDTH, 24, packed pixel width {r,g,b}.
- DATA_WIDTH, 8, width of each colour channel.
- IMG_WIDTH, 170, pixels per line.
- IMG_HEIGHT, 240, lines per frame.
- ADDR_WIDTH, $clog2(IMG_WIDTH*IMG_HEIGHT), frame buffer address width.

Ports:
- clk  in  1  system clock.
- reset  in  1  synchronous, active-high reset.
- start_write  in  1  one-cycle arm request; honoured only in IDLE.
- i_sof  in  1  start-of-frame pulse, coincident with or before the first pixel of a frame.
- i_de  in  1  pixel valid.
- i_r, i_g, i_b  in  DATA_WIDTH each  pixel channels, valid when i_de=1.
- addr  out  ADDR_WIDTH  buffer write address.
- we  out  1  buffer write enable.
- wdata  out  RGB_WIDTH  {r,g,b} write data.
- busy  out  1  high in WAIT_SOF and WRITE.
- done  out  1  one-cycle pulse: frame fully written.
- frame_err  out  1  one-cycle pulse: i_sof arrived mid-frame.

Behaviour:
- Reset values: all outputs 0, state IDLE, x/y/linear counters 0. Reset mid-frame drops any in-flight write, so we=0 on the cycle after reset. A new start_write is required after reset.
- All outputs are registered. Latency is 1 cycle: a pixel sampled at edge N (i_de=1 in WRITE) drives we=1, addr=index and wdata={i_r,i_g,i_b} after edge N, valid for one cycle.
- State IDLE:
  - start_write=1 -> WAIT_SOF.
  - i_sof and i_de are ignored.
- State WAIT_SOF:
  - i_sof=1 -> WRITE with counters cleared.
  - If i_de=1 on the same cycle as i_sof, that pixel is index 0 and is written.
  - i_de without a prior i_sof is ignored.
- State WRITE:
  - Each i_de=1 writes the current index, then increments it.
  - x wraps at IMG_WIDTH-1 and increments y.
  - The linear address is a running counter; no multiplier. Index = y*IMG_WIDTH + x.
  - i_de=0 cycles stall without writing; gaps are unlimited.
- Last pixel: i_de=1 at index IMG_WIDTH*IMG_HEIGHT-1 -> final write issued, done=1 on the same cycle as that we, then state goes to IDLE. busy drops on that same cycle.
- Extra pixels after done are ignored because the block is in IDLE.
- i_sof=1 in WRITE (not on index 0): frame_err pulses on the next cycle, counters restart. A pixel on that cycle (if i_de=1) becomes index 0. Previously written data stays in the buffer.
- start_write outside IDLE is ignored and has no effect on state.
- Simultaneous i_sof with the last pixel in WRITE: the restart takes priority, frame_err pulses and done does not pulse.
- Counter widths: x is $clog2(IMG_WIDTH) bits and y is $clog2(IMG_HEIGHT) bits. addr never exceeds IMG_WIDTH*IMG_HEIGHT-1.

Decomposition:
- Shared package img_pkg:
  - state enum (IDLE, WAIT_SOF, WRITE).
  - default IMG_WIDTH/IMG_HEIGHT/RGB_WIDTH/DATA_WIDTH constants, shared with the reader.
- Sub-module img_addr_counter:
  - x/y counters plus linear address, with clear, increment, last-pixel flag.
  - Reusable by the reader.
- The writer holds the FSM and the output register stage.

Test Plan (bench uses IMG_WIDTH=4, IMG_HEIGHT=3):
- Reset, start_write, i_sof with i_de, then 12 back-to-back pixels of value 0x000000..0x00000B -> we high 12 consecutive cycles, addr 0..11, wdata = index, done=1 with addr=11, busy=0 afterwards.
- Same frame with i_de toggled every other cycle -> addr sequence 0..11 without gaps or duplicates, we only on cycles following an accepted pixel, done once.
- i_de pixels in WAIT_SOF before i_sof, then 5 pixels after i_sof -> pre-sof pixels never written. Writes go to addr 0..4.
- i_sof reasserted at index 6 with i_de=1 -> frame_err pulse, that pixel written at addr 0, a full 12 writes then done.
- reset asserted at index 7 -> we=0 next cycle, busy=0. Subsequent i_sof/i_de produce no writes until a new start_write.
- 3 extra pixels after done, and start_write pulsed during WRITE -> no writes after done, and the state trace is unaffected by the mid-frame start_write.
